// File: rtl/param_midi_encoder.sv
// param_midi_encoder: queues parameter writes and serialises them as MIDI Control Change bytes
module param_midi_encoder #(
   parameter int VALUE_WIDTH    = 16,
   parameter int MIDI_CHANNEL   = 0,
   parameter int CC_BASE        = 20,
   parameter int FIFO_DEPTH     = 4,
   parameter int RUNNING_STATUS = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [2:0]             param_addr,
   input  logic [VALUE_WIDTH-1:0] param_value,
   input  logic                   param_valid,
   output logic                   param_ready,
   output logic [7:0]             midi_data,
   output logic                   midi_valid,
   input  logic                   midi_ready,
   output logic                   busy
);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
   localparam logic [7:0] STATUS = 8'hB0 | 8'(MIDI_CHANNEL % 16);
   localparam logic [6:0] CC_BASE7 = 7'(CC_BASE % 128);
   typedef enum logic [1:0] {IDLE, SEND_STATUS, SEND_CTRL, SEND_DATA} state_t;
   state_t state_q, state_d;
   logic [9:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic [9:0] hold_q, hold_d, head;
   logic [7:0] data_q, data_d;
   logic valid_q, valid_d, rs_q, rs_d, push, pop, avail, xfer, start;
   logic unused_value;
   assign unused_value = ^param_value;
   assign param_ready = count_q != FULL;
   assign push = param_valid && param_ready;
   assign avail = count_q != '0;
   assign head = mem_q[rd_ptr_q];
   assign xfer = valid_q && midi_ready;
   assign midi_data = data_q;
   assign midi_valid = valid_q;
   assign busy = avail || state_q != IDLE;
   // controller number wraps within 7 bits
   function automatic logic [7:0] ctrl_byte(input logic [9:0] e);
      return {1'b0, CC_BASE7 + {4'b0, e[9:7]}};
   endfunction
   always_ff @(posedge clk)
      if (push) mem_q[wr_ptr_q] <= {param_addr, param_value[VALUE_WIDTH-1 -: 7]};
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      data_d  = data_q;
      valid_d = valid_q;
      rs_d    = rs_q;
      pop     = 1'b0;
      start   = avail && (state_q == IDLE || (state_q == SEND_DATA && xfer));
      case (state_q)
         SEND_STATUS: if (xfer) begin
            rs_d    = 1'b1;
            data_d  = ctrl_byte(hold_q);
            state_d = SEND_CTRL;
         end
         SEND_CTRL: if (xfer) begin
            data_d  = {1'b0, hold_q[6:0]};
            state_d = SEND_DATA;
         end
         SEND_DATA: if (xfer) begin
            valid_d = 1'b0;
            state_d = IDLE;
         end
         default: ;
      endcase
      // back-to-back: a new message may start on the same edge the data byte leaves
      if (start) begin
         pop     = 1'b1;
         hold_d  = head;
         valid_d = 1'b1;
         state_d = (RUNNING_STATUS != 0 && rs_q) ? SEND_CTRL : SEND_STATUS;
         data_d  = (RUNNING_STATUS != 0 && rs_q) ? ctrl_byte(head) : STATUS;
      end
   end
   always_ff @(posedge clk)
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         state_q  <= IDLE;
         hold_q   <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         rs_q     <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_q + AW'(push);
         rd_ptr_q <= rd_ptr_q + AW'(pop);
         count_q  <= count_q + CW'(push) - CW'(pop);
         state_q  <= state_d;
         hold_q   <= hold_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         rs_q     <= rs_d;
      end
endmodule
